pb_field_encode_arb: RTL and testbench

- Shares one hardware protobuf field serializer between NUM_REQ requesters.
- Each accepted request (field number, wire type, value) is emitted as a little-endian byte stream: message key varint first, then the payload.
- Payload is a varint for wire types 0 and 2, or fixed LE bytes for wire types 1 and 5.
- Sits between field producers and the message byte-stream packer; round-robin grant, valid/ready on both sides.

---
 rtl/pb_hw_pkg.sv | 36 +++
 rtl/pb_rr_arbiter.sv | 49 ++++
 rtl/pb_field_encode_arb.sv | 162 ++++++++++++++++
 tb/tb_pb_field_encode_arb.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pb_hw_pkg.sv
// Shared protobuf encoder types: wire types, size limits and the field-serializer FSM state.
package pb_hw_pkg;

   typedef enum logic [2:0] {
      VARINT = 3'd0,
      I64    = 3'd1,
      LEN    = 3'd2,
      SGROUP = 3'd3,
      EGROUP = 3'd4,
      I32    = 3'd5
   } wire_type_e;

   localparam int unsigned MAX_VARINT_BYTES = 10;
   localparam int unsigned MAX_KEY_BYTES    = 5;
   localparam int unsigned KEY_W            = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_KEY,
      ST_VAL,
      ST_ERR
   } fsm_state_e;

   // Group wire types and the unassigned codes 6/7 are not serializable.
   function automatic logic wt_illegal(input logic [2:0] wt);
      case (wt)
         VARINT, I64, LEN, I32: return 1'b0;
         default:               return 1'b1;
      endcase
   endfunction

   function automatic logic wt_fixed(input logic [2:0] wt);
      return (wt == I64) || (wt == I32);
   endfunction

endpackage

// File: rtl/pb_rr_arbiter.sv
// Round-robin arbiter: first valid requester at or after the pointer wins; the
// pointer moves just past the winner whenever a grant is taken.
module pb_rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req_i,
   input  logic               grant_en_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0]   gnt_idx_o,
   output logic               gnt_any_o
);

   localparam int unsigned N = NUM_REQ;

   logic [IDX_W-1:0] ptr_q, ptr_d;
   int unsigned      idx;

   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      gnt_any_o = 1'b0;
      idx       = 0;
      for (int unsigned off = 0; off < N; off++) begin
         idx = 32'(ptr_q) + off;
         if (idx >= N) idx = idx - N;
         if (!gnt_any_o && req_i[IDX_W'(idx)]) begin
            gnt_any_o = 1'b1;
            gnt_idx_o = IDX_W'(idx);
         end
      end
      gnt_o[gnt_idx_o] = gnt_any_o;
   end

   always_comb begin
      ptr_d = ptr_q;
      if (grant_en_i && gnt_any_o) begin
         ptr_d = (gnt_idx_o == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_o + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

endmodule

// File: rtl/pb_field_encode_arb.sv
// Shared protobuf field serializer: arbitrates NUM_REQ producers and emits each
// accepted field as key varint followed by a varint or fixed little-endian payload.
module pb_field_encode_arb
   import pb_hw_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   parameter  int FN_W    = 29,
   parameter  int VAL_W   = 64,
   localparam int SRC_W   = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*FN_W-1:0]  req_field_number,
   input  logic [NUM_REQ*3-1:0]     req_wire_type,
   input  logic [NUM_REQ*VAL_W-1:0] req_value,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [7:0]               out_byte,
   output logic                     out_last,
   output logic [SRC_W-1:0]         out_src,
   output logic                     err_illegal,
   output logic                     busy
);

   fsm_state_e       state_q, state_d;
   logic [VAL_W-1:0] sr_q, sr_d;
   logic [VAL_W-1:0] val_q, val_d;
   wire_type_e       wt_q, wt_d;
   logic [SRC_W-1:0] src_q, src_d;
   logic [3:0]       cnt_q, cnt_d;

   logic [NUM_REQ-1:0] gnt;
   logic [SRC_W-1:0]   gnt_idx;
   logic               gnt_any;
   logic               grant_en;

   logic [FN_W-1:0]  sel_fn;
   logic [2:0]       sel_wt;
   logic [VAL_W-1:0] sel_val;
   logic [KEY_W-1:0] sel_key;
   logic             sel_illegal;

   logic       hs;
   logic       rest_nz;
   logic       fixed;
   logic [3:0] fix_last;
   logic [3:0] cnt_inc;

   pb_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .clk        (clk),
      .rst        (rst),
      .req_i      (req_valid),
      .grant_en_i (grant_en),
      .gnt_o      (gnt),
      .gnt_idx_o  (gnt_idx),
      .gnt_any_o  (gnt_any)
   );

   assign grant_en  = (state_q == ST_IDLE) && !rst;
   assign req_ready = grant_en ? gnt : '0;

   assign sel_fn      = req_field_number[int'(gnt_idx)*FN_W +: FN_W];
   assign sel_wt      = req_wire_type[int'(gnt_idx)*3 +: 3];
   assign sel_val     = req_value[int'(gnt_idx)*VAL_W +: VAL_W];
   assign sel_key     = KEY_W'({sel_fn, sel_wt});
   assign sel_illegal = (sel_fn == '0) || wt_illegal(sel_wt);

   // One shift register serves key and payload; rest_nz is the varint continuation bit.
   assign rest_nz  = |sr_q[VAL_W-1:7];
   assign fixed    = wt_fixed(wt_q);
   assign fix_last = (wt_q == I64) ? 4'd7 : 4'd3;
   assign cnt_inc  = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

   assign out_valid   = (state_q == ST_KEY) || (state_q == ST_VAL);
   assign out_byte    = (state_q == ST_VAL && fixed) ? sr_q[7:0] : {rest_nz, sr_q[6:0]};
   assign out_last    = (state_q == ST_VAL) && (fixed ? (cnt_q == fix_last) : !rest_nz);
   assign out_src     = src_q;
   assign err_illegal = (state_q == ST_ERR);
   assign busy        = (state_q != ST_IDLE);
   assign hs          = out_valid && out_ready;

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      val_d   = val_q;
      wt_d    = wt_q;
      src_d   = src_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_en && gnt_any) begin
               src_d   = gnt_idx;
               wt_d    = wire_type_e'(sel_wt);
               val_d   = sel_val;
               sr_d    = VAL_W'(sel_key);
               cnt_d   = '0;
               state_d = sel_illegal ? ST_ERR : ST_KEY;
            end
         end
         ST_KEY: begin
            if (hs) begin
               if (!rest_nz) begin
                  sr_d    = val_q;
                  cnt_d   = '0;
                  state_d = ST_VAL;
               end else begin
                  sr_d  = sr_q >> 7;
                  cnt_d = cnt_inc;
               end
            end
         end
         ST_VAL: begin
            if (hs) begin
               if (out_last) begin
                  state_d = ST_IDLE;
               end else begin
                  sr_d  = fixed ? (sr_q >> 8) : (sr_q >> 7);
                  cnt_d = cnt_inc;
               end
            end
         end
         ST_ERR: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sr_q    <= '0;
         val_q   <= '0;
         wt_q    <= VARINT;
         src_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         val_q   <= val_d;
         wt_q    <= wt_d;
         src_q   <= src_d;
         cnt_q   <= cnt_d;
      end
   end

   a_varint_len: assert property (@(posedge clk) disable iff (rst)
      !(state_q == ST_VAL && !fixed && cnt_q >= 4'(MAX_VARINT_BYTES)));
   a_key_len: assert property (@(posedge clk) disable iff (rst)
      !(state_q == ST_KEY && cnt_q >= 4'(MAX_KEY_BYTES)));
   a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_hold
      a_req_hold: assert property (@(posedge clk) disable iff (rst)
         (req_valid[i] && !req_ready[i]) |=>
            (req_valid[i] && $stable(req_field_number[i*FN_W +: FN_W]) &&
             $stable(req_wire_type[i*3 +: 3]) && $stable(req_value[i*VAL_W +: VAL_W])));
   end

endmodule

// File: tb/tb_pb_field_encode_arb.sv
// Scoreboard bench: grants are predicted by a round-robin model and each granted
// field is expanded into its expected byte stream, which a monitor pops and compares.
module tb_pb_field_encode_arb;

   localparam int NUM_REQ = 4;
   localparam int FN_W    = 29;
   localparam int VAL_W   = 64;
   localparam int SRC_W   = 2;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*FN_W-1:0]  req_field_number;
   logic [NUM_REQ*3-1:0]     req_wire_type;
   logic [NUM_REQ*VAL_W-1:0] req_value;
   logic                     out_valid;
   logic                     out_ready;
   logic [7:0]               out_byte;
   logic                     out_last;
   logic [SRC_W-1:0]         out_src;
   logic                     err_illegal;
   logic                     busy;

   always #5 clk = ~clk;

   pb_field_encode_arb #(
      .NUM_REQ (NUM_REQ),
      .FN_W    (FN_W),
      .VAL_W   (VAL_W)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_field_number (req_field_number),
      .req_wire_type    (req_wire_type),
      .req_value        (req_value),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_byte         (out_byte),
      .out_last         (out_last),
      .out_src          (out_src),
      .err_illegal      (err_illegal),
      .busy             (busy)
   );

   typedef struct {
      logic [7:0] b;
      logic       last;
      int         src;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int unsigned ptr_m = 0;
   logic        err_due = 1'b0;
   int          tmo_n = 0;
   int          tmo_seen = 0;
   logic        rnd_ready = 1'b0;

   task automatic chk(input string name, input longint unsigned act, input longint unsigned req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Protobuf varint: 7 bits per byte, least significant group first, MSB = more follows.
   function automatic void push_varint(input longint unsigned v, input int src, input logic payload);
      exp_t e;
      longint unsigned grp;
      do begin
         grp   = v % 128;
         v     = v / 128;
         e.b   = 8'(grp + ((v != 0) ? 128 : 0));
         e.last = payload && (v == 0);
         e.src = src;
         exp_q.push_back(e);
      end while (v != 0);
   endfunction

   function automatic void push_field(input int src, input longint unsigned fn,
                                      input int unsigned wt, input longint unsigned v);
      exp_t e;
      int   n;
      push_varint(fn * 8 + wt, src, 1'b0);
      if (wt == 0 || wt == 2) begin
         push_varint(v, src, 1'b1);
      end else begin
         n = (wt == 1) ? 8 : 4;
         for (int k = 0; k < n; k++) begin
            e.b    = 8'((v >> (8 * k)) % 256);
            e.last = (k == n - 1);
            e.src  = src;
            exp_q.push_back(e);
         end
      end
   endfunction

   function automatic logic legal_m(input longint unsigned fn, input int unsigned wt);
      return (fn != 0) && (wt == 0 || wt == 1 || wt == 2 || wt == 5);
   endfunction

   always @(negedge clk) begin
      exp_t            e;
      logic [NUM_REQ-1:0] exp_gnt;
      logic            found;
      logic            busy_exp;
      logic            err_next;
      int unsigned     g;
      int unsigned     idx;
      longint unsigned fn;
      int unsigned     wt;
      longint unsigned v;

      if (tmo_n != tmo_seen) begin
         chk("idle_timeout", 64'(tmo_n), 64'(tmo_seen));
         tmo_seen = tmo_n;
      end

      if (rst) begin
         chk("rst_out_valid", out_valid, 0);
         chk("rst_req_ready", req_ready, 0);
         chk("rst_busy", busy, 0);
         chk("rst_err", err_illegal, 0);
         exp_q.delete();
         ptr_m   = 0;
         err_due = 1'b0;
      end else begin
         busy_exp = (exp_q.size() != 0) || err_due;
         chk("out_valid", out_valid, (exp_q.size() != 0) ? 1 : 0);
         chk("busy", busy, busy_exp);
         chk("err_illegal", err_illegal, err_due);

         if (out_valid && exp_q.size() != 0) begin
            e = exp_q[0];
            chk("out_byte", out_byte, e.b);
            chk("out_last", out_last, e.last);
            chk("out_src", out_src, 64'(e.src));
            if (out_ready) void'(exp_q.pop_front());
         end

         err_next = 1'b0;
         exp_gnt  = '0;
         found    = 1'b0;
         g        = 0;
         if (!busy_exp) begin
            for (int unsigned off = 0; off < NUM_REQ; off++) begin
               idx = (ptr_m + off) % NUM_REQ;
               if (!found && req_valid[idx]) begin
                  found = 1'b1;
                  g     = idx;
               end
            end
         end
         if (found) exp_gnt[g] = 1'b1;
         chk("req_ready", req_ready, exp_gnt);

         if (found) begin
            ptr_m = (g + 1) % NUM_REQ;
            fn = 64'(req_field_number[g*FN_W +: FN_W]);
            wt = 32'(req_wire_type[g*3 +: 3]);
            v  = req_value[g*VAL_W +: VAL_W];
            if (legal_m(fn, wt)) push_field(int'(g), fn, wt, v);
            else err_next = 1'b1;
         end
         err_due = err_next;
      end
   end

   // Main process advances at posedge+1; consumed requests are withdrawn there.
   task automatic step();
      logic [NUM_REQ-1:0] snap;
      @(negedge clk);
      snap = req_ready;
      @(posedge clk);
      #1;
      req_valid = req_valid & ~snap;
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic issue(input int i, input longint unsigned fn, input int unsigned wt,
                        input longint unsigned v);
      req_field_number[i*FN_W +: FN_W] = FN_W'(fn);
      req_wire_type[i*3 +: 3]          = 3'(wt);
      req_value[i*VAL_W +: VAL_W]      = v;
      req_valid[i]                     = 1'b1;
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 400; n++) begin
         if (req_valid == '0 && exp_q.size() == 0 && !err_due) begin
            step();
            return;
         end
         step();
      end
      tmo_n++;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '0;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      int          issued;
      int unsigned wts[10];
      longint unsigned fn_r;
      longint unsigned v_r;

      wts = '{0, 0, 1, 1, 2, 2, 5, 5, 3, 7};
      rst              = 1'b1;
      req_valid        = '0;
      req_field_number = '0;
      req_wire_type    = '0;
      req_value        = '0;
      out_ready        = 1'b0;
      step();
      step();
      step();
      rst       = 1'b0;
      out_ready = 1'b1;

      issue(0, 1, 0, 150);                     wait_idle();
      issue(0, 16, 0, 1);                      wait_idle();
      issue(0, 1, 0, 0);                       wait_idle();
      issue(0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF); wait_idle();
      issue(0, 5, 5, 64'h1234_5678);           wait_idle();
      issue(0, 3, 1, 64'h0102_0304_0506_0708); wait_idle();
      issue(1, 29'h1FFF_FFFF, 2, 300);         wait_idle();

      do_reset();
      issued = 0;
      for (int n = 0; n < 200 && issued < 8; n++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!req_valid[i] && issued < 8) begin
               issue(i, 64'(10 + issued), 0, 64'(issued * 1000));
               issued++;
            end
         end
         step();
      end
      wait_idle();

      do_reset();
      issue(2, 7, 0, 300);
      wait_idle();
      for (int i = 0; i < NUM_REQ; i++) issue(i, 64'(20 + i), 5, 64'(i));
      wait_idle();

      issue(0, 1, 0, 150);
      step();
      step();
      out_ready = 1'b0;
      step();
      step();
      step();
      out_ready = 1'b1;
      wait_idle();

      issue(0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF);
      step();
      step();
      step();
      step();
      rst       = 1'b1;
      req_valid = '0;
      step();
      step();
      rst = 1'b0;
      issue(1, 2, 0, 5);
      issue(0, 4, 0, 9);
      wait_idle();

      issue(0, 0, 0, 5);    wait_idle();
      issue(0, 9, 3, 5);    wait_idle();
      issue(1, 9, 7, 1);    wait_idle();
      issue(0, 1, 0, 150);  wait_idle();

      rnd_ready = 1'b1;
      for (int n = 0; n < 1500; n++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
               fn_r = ($urandom_range(0, 15) == 0) ? 0 :
                      (64'($urandom) % 64'h2000_0000) >> $urandom_range(0, 28);
               v_r  = {$urandom, $urandom} >> $urandom_range(0, 63);
               issue(i, fn_r, wts[$urandom_range(0, 9)], v_r);
            end
         end
         step();
      end
      wait_idle();
      rnd_ready = 1'b0;
      out_ready = 1'b1;
      step();
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
